exhaustive_response_compactor: RTL and testbench



---
 rtl/exhaustive_response_compactor_if.sv | 38 +++
 rtl/exhaustive_response_compactor.sv | 119 +++++++++++
 tb/tb_exhaustive_response_compactor.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_response_compactor_if.sv
// Handshake and result bundle between the exhaustive-stimulus harness and the response compactor.
// Optional resp_map signal is present when RESP_MAP_EN is defined.
interface exhaustive_response_compactor_if #(
   parameter int VEC_W = 7,
   parameter int SIG_W = 16
);
   logic             start;
   logic             vec_valid;
   logic [VEC_W-1:0] vec_in;
   logic             resp_in;
   logic             vec_ready;
   logic             busy;
   logic             done;
   logic             seq_err;
   logic [SIG_W-1:0] signature;
   logic [VEC_W:0]   ones_count;
`ifdef RESP_MAP_EN
   logic [(1<<VEC_W)-1:0] resp_map;

   modport master (
      output start, vec_valid, vec_in, resp_in,
      input  vec_ready, busy, done, seq_err, signature, ones_count, resp_map
   );
   modport slave (
      input  start, vec_valid, vec_in, resp_in,
      output vec_ready, busy, done, seq_err, signature, ones_count, resp_map
   );
`else
   modport master (
      output start, vec_valid, vec_in, resp_in,
      input  vec_ready, busy, done, seq_err, signature, ones_count
   );
   modport slave (
      input  start, vec_valid, vec_in, resp_in,
      output vec_ready, busy, done, seq_err, signature, ones_count
   );
`endif
endinterface

// File: rtl/exhaustive_response_compactor.sv
// Compacts 2^VEC_W single-bit DUT responses into a MISR signature and ones count, checking vector order.
// Define RESP_MAP_EN to also keep a per-vector response map for diagnosis.
module exhaustive_response_compactor #(
   parameter int               VEC_W = 7,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
   input  logic                            CK,
   input  logic                            reset,
   exhaustive_response_compactor_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_n;
   logic             busy_r;
   logic             done_r;
   logic             seq_err_r;
   logic [SIG_W-1:0] sig_r;
   logic [VEC_W:0]   ones_r;
   logic [VEC_W-1:0] exp_idx_r;
   logic             accept_s;
   logic             start_ok_s;
   logic             last_s;

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic bit_in);
      misr_step = {sig[SIG_W-2:0], 1'b0}
                ^ (sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                ^ {{(SIG_W-1){1'b0}}, bit_in};
   endfunction

   assign accept_s   = bus.vec_valid && (state_r == RUN);
   assign start_ok_s = bus.start && (state_r != RUN);
   assign last_s     = (exp_idx_r == {VEC_W{1'b1}});

   // Run-control next-state logic; start is ignored while a run is in progress.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) state_n = RUN;
            else           state_n = IDLE;
         end
         RUN: begin
            if (accept_s && last_s) state_n = DONE;
            else                    state_n = RUN;
         end
         DONE: begin
            if (bus.start) state_n = RUN;
            else           state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register with status flags registered from the next state.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         busy_r  <= (state_n == RUN);
         done_r  <= (state_n == DONE);
      end
   end

   // Compaction datapath: a restart clears results, each accept folds one response in.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         sig_r     <= SEED;
         ones_r    <= {(VEC_W+1){1'b0}};
         exp_idx_r <= {VEC_W{1'b0}};
         seq_err_r <= 1'b0;
      end else if (start_ok_s) begin
         sig_r     <= SEED;
         ones_r    <= {(VEC_W+1){1'b0}};
         exp_idx_r <= {VEC_W{1'b0}};
         seq_err_r <= 1'b0;
      end else if (accept_s) begin
         sig_r     <= misr_step(sig_r, bus.resp_in);
         ones_r    <= ones_r + {{VEC_W{1'b0}}, bus.resp_in};
         exp_idx_r <= exp_idx_r + {{(VEC_W-1){1'b0}}, 1'b1};
         seq_err_r <= seq_err_r | (bus.vec_in != exp_idx_r);
      end
   end

`ifdef RESP_MAP_EN
   logic [(1<<VEC_W)-1:0] resp_map_r;

   // Map is indexed by the vector actually received so misordered runs stay diagnosable.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         resp_map_r <= {(1<<VEC_W){1'b0}};
      end else if (start_ok_s) begin
         resp_map_r <= {(1<<VEC_W){1'b0}};
      end else if (accept_s) begin
         resp_map_r[bus.vec_in] <= bus.resp_in;
      end
   end

   assign bus.resp_map = resp_map_r;
`endif

   assign bus.vec_ready  = busy_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.seq_err    = seq_err_r;
   assign bus.signature  = sig_r;
   assign bus.ones_count = ones_r;

endmodule

// File: tb/tb_exhaustive_response_compactor.sv
// Directed self-checking bench for exhaustive_response_compactor (VEC_W=7, SIG_W=16, POLY=16'h1021, SEED=0).
module tb_exhaustive_response_compactor;

   logic CK;
   logic reset;
   int   total;
   int   bad;

   exhaustive_response_compactor_if #(.VEC_W(7), .SIG_W(16)) bus ();

   exhaustive_response_compactor #(
      .VEC_W(7), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)
   ) dut (
      .CK    (CK),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   // Response pattern per position: 0 none, 1 only 127, 2 only 126, 3 all, 4 odd, 5 120 and 127, 6 only 111
   function automatic logic resp_of(input int mode, input int i);
      case (mode)
         0:       resp_of = 1'b0;
         1:       resp_of = (i == 127);
         2:       resp_of = (i == 126);
         3:       resp_of = 1'b1;
         4:       resp_of = i[0];
         5:       resp_of = (i == 120) || (i == 127);
         6:       resp_of = (i == 111);
         default: resp_of = 1'b0;
      endcase
   endfunction

   // All stimulus tasks start and end at a falling edge.
   task automatic drive(input logic [6:0] v, input logic r);
      bus.vec_valid = 1'b1;
      bus.vec_in    = v;
      bus.resp_in   = r;
      @(negedge CK);
      bus.vec_valid = 1'b0;
   endtask

   task automatic run_range(input int mode, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) drive(i[6:0], resp_of(mode, i));
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge CK);
      bus.start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge CK);
      reset = 1'b0;
      @(negedge CK);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge CK);
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_ready !== 1'b0 || bus.seq_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got busy=%b done=%b ready=%b seq=%b want 0000",
                  bus.busy, bus.done, bus.vec_ready, bus.seq_err);
      end
      total++;
      if (bus.signature !== 16'h0000 || bus.ones_count !== 8'h00) begin
         bad++;
         $display("FAIL reset_values got sig=%h ones=%h want 0000 00", bus.signature, bus.ones_count);
      end
      reset = 1'b0;
      @(negedge CK);
   endtask

   task automatic test_zero_run();
      do_reset();
      pulse_start();
      total++;
      if (bus.busy !== 1'b1 || bus.vec_ready !== 1'b1) begin
         bad++;
         $display("FAIL start_busy got busy=%b ready=%b want 1 1", bus.busy, bus.vec_ready);
      end
      run_range(0, 0, 126);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL done_early got done=%b busy=%b want 0 1", bus.done, bus.busy);
      end
      drive(7'd127, 1'b0);
      total++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.vec_ready !== 1'b0) begin
         bad++;
         $display("FAIL done_rise got done=%b busy=%b ready=%b want 1 0 0", bus.done, bus.busy, bus.vec_ready);
      end
      total++;
      if (bus.signature !== 16'h0000 || bus.ones_count !== 8'd0 || bus.seq_err !== 1'b0) begin
         bad++;
         $display("FAIL zero_run got sig=%h ones=%h seq=%b want 0000 00 0",
                  bus.signature, bus.ones_count, bus.seq_err);
      end
   endtask

   task automatic test_last_resp();
      do_reset();
      pulse_start();
      run_range(1, 0, 127);
      total++;
      if (bus.signature !== 16'h0001 || bus.ones_count !== 8'd1) begin
         bad++;
         $display("FAIL resp_127 got sig=%h ones=%h want 0001 01", bus.signature, bus.ones_count);
      end
      // Restart directly from DONE must clear previous results.
      pulse_start();
      total++;
      if (bus.signature !== 16'h0000 || bus.ones_count !== 8'd0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL restart_clear got sig=%h ones=%h done=%b busy=%b want 0000 00 0 1",
                  bus.signature, bus.ones_count, bus.done, bus.busy);
      end
      run_range(2, 0, 127);
      total++;
      if (bus.signature !== 16'h0002 || bus.ones_count !== 8'd1 || bus.done !== 1'b1) begin
         bad++;
         $display("FAIL resp_126 got sig=%h ones=%h done=%b want 0002 01 1",
                  bus.signature, bus.ones_count, bus.done);
      end
   endtask

   task automatic test_poly_feedback();
      do_reset();
      pulse_start();
      run_range(6, 0, 127);
      total++;
      if (bus.signature !== 16'h1021) begin
         bad++;
         $display("FAIL poly_fb got sig=%h want 1021", bus.signature);
      end
   endtask

   task automatic test_all_ones();
      do_reset();
      pulse_start();
      run_range(3, 0, 127);
      total++;
      if (bus.ones_count !== 8'h80 || bus.done !== 1'b1) begin
         bad++;
         $display("FAIL all_ones got ones=%h done=%b want 80 1", bus.ones_count, bus.done);
      end
   endtask

   task automatic test_seq_err();
      do_reset();
      pulse_start();
      run_range(4, 0, 2);
      total++;
      if (bus.seq_err !== 1'b0) begin
         bad++;
         $display("FAIL seq_before got %b want 0", bus.seq_err);
      end
      drive(7'd5, resp_of(4, 3));
      total++;
      if (bus.seq_err !== 1'b1) begin
         bad++;
         $display("FAIL seq_set got %b want 1", bus.seq_err);
      end
      run_range(4, 4, 127);
      total++;
      if (bus.seq_err !== 1'b1 || bus.done !== 1'b1 || bus.ones_count !== 8'd64) begin
         bad++;
         $display("FAIL seq_done got seq=%b done=%b ones=%h want 1 1 40",
                  bus.seq_err, bus.done, bus.ones_count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pulse_start();
      run_range(4, 0, 59);
      reset = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.vec_ready !== 1'b0 || bus.done !== 1'b0 || bus.seq_err !== 1'b0) begin
         bad++;
         $display("FAIL async_flags got busy=%b ready=%b done=%b seq=%b want 0000",
                  bus.busy, bus.vec_ready, bus.done, bus.seq_err);
      end
      total++;
      if (bus.signature !== 16'h0000 || bus.ones_count !== 8'd0) begin
         bad++;
         $display("FAIL async_values got sig=%h ones=%h want 0000 00", bus.signature, bus.ones_count);
      end
      #2;
      reset = 1'b0;
      @(negedge CK);
      pulse_start();
      run_range(5, 0, 127);
      total++;
      if (bus.signature !== 16'h0081 || bus.ones_count !== 8'd2 || bus.done !== 1'b1) begin
         bad++;
         $display("FAIL after_reset_run got sig=%h ones=%h done=%b want 0081 02 1",
                  bus.signature, bus.ones_count, bus.done);
      end
   endtask

   task automatic test_ignored_controls();
      do_reset();
      bus.vec_valid = 1'b1;
      bus.vec_in    = 7'd0;
      bus.resp_in   = 1'b1;
      repeat (2) @(negedge CK);
      bus.vec_valid = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.ones_count !== 8'd0 || bus.signature !== 16'h0000) begin
         bad++;
         $display("FAIL valid_in_idle got busy=%b ones=%h sig=%h want 0 00 0000",
                  bus.busy, bus.ones_count, bus.signature);
      end
      pulse_start();
      run_range(5, 0, 63);
      pulse_start();
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL start_in_run got busy=%b done=%b want 1 0", bus.busy, bus.done);
      end
      run_range(5, 64, 127);
      total++;
      if (bus.signature !== 16'h0081 || bus.ones_count !== 8'd2 || bus.seq_err !== 1'b0 || bus.done !== 1'b1) begin
         bad++;
         $display("FAIL run_with_restart got sig=%h ones=%h seq=%b done=%b want 0081 02 0 1",
                  bus.signature, bus.ones_count, bus.seq_err, bus.done);
      end
      drive(7'd9, 1'b1);
      drive(7'd0, 1'b1);
      total++;
      if (bus.signature !== 16'h0081 || bus.ones_count !== 8'd2 || bus.done !== 1'b1 || bus.seq_err !== 1'b0) begin
         bad++;
         $display("FAIL done_hold got sig=%h ones=%h done=%b seq=%b want 0081 02 1 0",
                  bus.signature, bus.ones_count, bus.done, bus.seq_err);
      end
   endtask

`ifdef RESP_MAP_EN
   task automatic test_resp_map();
      logic [127:0] exp_map;
      exp_map = {64{2'b10}};
      do_reset();
      total++;
      if (bus.resp_map !== 128'd0) begin
         bad++;
         $display("FAIL map_reset got %h want 0", bus.resp_map);
      end
      pulse_start();
      run_range(4, 0, 127);
      total++;
      if (bus.resp_map !== exp_map) begin
         bad++;
         $display("FAIL map_alt got %h want %h", bus.resp_map, exp_map);
      end
   endtask
`endif

   initial begin
      total         = 0;
      bad           = 0;
      bus.start     = 1'b0;
      bus.vec_valid = 1'b0;
      bus.vec_in    = 7'd0;
      bus.resp_in   = 1'b0;
      test_reset();
      test_zero_run();
      test_last_resp();
      test_poly_feedback();
      test_all_ones();
      test_seq_err();
      test_async_reset();
      test_ignored_controls();
`ifdef RESP_MAP_EN
      test_resp_map();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
